// File: rtl/decode_seq.sv
// decode_seq: sequenced instruction decoder with an internal FETCH/EXEC/WAIT phase.
//
// The block drives the 13-bit datapath control word, ordered from MSB to LSB as
// incPC, loadPC, loadA, loadFlags, fun[2:0], csRAM, weRAM, oeALU, oeIN, oeOprnd, loadOut.
// Instructions that select RAM get WAIT_CYCLES extra execute cycles. During those
// cycles the non-strobe fields stay steady and the strobes fire only in the last cycle.
//
// Optional build macro DECODE_SEQ_STEP_EN adds step_i. With it defined, each
// FETCH -> EXEC advance also needs a rising edge on step_i.
//
// Parameters:
//   WAIT_CYCLES  extra execute cycles for RAM instructions (0 = none)
//   CNT_W        wait counter width, WAIT_CYCLES <= 2**CNT_W - 1
// Ports:
//   clock_i      system clock, rising edge
//   reset_ni     asynchronous active-low reset; all outputs are 0 while low
//   enable_i     1 = advance; 0 = hold state/counter and force strobes low
//   z_flag_i     zero flag
//   c_flag_i     carry flag
//   instr_i      current opcode, stable from EXEC entry to end of WAIT
//   step_i       single-step request (DECODE_SEQ_STEP_EN only)
//   phase_o      0 = FETCH, 1 = EXEC/WAIT
//   busy_o       1 while in WAIT
//   remaining outputs: the control word fields listed above
module decode_seq #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned CNT_W       = 4
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       enable_i,
   input  logic       z_flag_i,
   input  logic       c_flag_i,
`ifdef DECODE_SEQ_STEP_EN
   input  logic       step_i,
`endif
   input  logic [3:0] instr_i,
   output logic       phase_o,
   output logic       busy_o,
   output logic       inc_pc_o,
   output logic       load_pc_o,
   output logic       load_a_o,
   output logic       load_flags_o,
   output logic [2:0] fun_o,
   output logic       cs_ram_o,
   output logic       we_ram_o,
   output logic       oe_alu_o,
   output logic       oe_in_o,
   output logic       oe_oprnd_o,
   output logic       load_out_o
);

   if (WAIT_CYCLES > (2 ** CNT_W) - 1) begin : gen_bad_wait_cycles
      $error("decode_seq: WAIT_CYCLES does not fit in CNT_W bits");
   end

   localparam logic [12:0] FetchWord   = 13'b1000_000_001000;
   localparam logic [12:0] JumpTaken   = 13'b0100_000_001000;
   localparam logic [12:0] JumpSkip    = 13'b1000_000_001000;
   // incPC, loadPC, loadA, loadFlags, weRAM, loadOut
   localparam logic [12:0] StrobeMask  = 13'b1111_000_010001;
   localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StFetch, StExec, StWait} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [12:0]      exec_word;
   logic [12:0]      word;
   logic             has_wait;
   logic             step_ok;

`ifdef DECODE_SEQ_STEP_EN
   logic step_q;
   assign step_ok = step_i & ~step_q;
`else
   assign step_ok = 1'b1;
`endif

   // Execute-phase control word, with the conditional jumps already resolved.
   always_comb begin
      exec_word = '0;
      case (instr_i)
         4'b0000: exec_word = c_flag_i ? JumpTaken : JumpSkip;  // JC
         4'b0001: exec_word = c_flag_i ? JumpSkip : JumpTaken;  // JNC
         4'b0010: exec_word = 13'b0001_001_000010;              // CMPI
         4'b0011: exec_word = 13'b1001_001_100000;              // CMPM
         4'b0100: exec_word = 13'b0011_010_000010;              // LIT
         4'b0101: exec_word = 13'b0011_010_000100;              // IN
         4'b0110: exec_word = 13'b1011_010_100000;              // LD
         4'b0111: exec_word = 13'b1000_000_111000;              // ST
         4'b1000: exec_word = z_flag_i ? JumpTaken : JumpSkip;  // JZ
         4'b1001: exec_word = z_flag_i ? JumpSkip : JumpTaken;  // JNZ
         4'b1010: exec_word = 13'b0011_011_000010;              // ADDI
         4'b1011: exec_word = 13'b1011_011_100000;              // ADDM
         4'b1100: exec_word = 13'b0100_000_001000;              // JMP
         4'b1101: exec_word = 13'b0000_000_001001;              // OUT
         4'b1110: exec_word = 13'b0011_100_000010;              // NANDI
         4'b1111: exec_word = 13'b1011_100_100000;              // NANDM
         default: exec_word = '0;
      endcase
   end

   assign has_wait = exec_word[5] && (WAIT_CYCLES > 0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (enable_i) begin
         case (state_q)
            StFetch: if (step_ok) state_d = StExec;
            StExec: begin
               if (has_wait) begin
                  state_d = StWait;
                  cnt_d   = WaitLoad;
               end else begin
                  state_d = StFetch;
               end
            end
            StWait: begin
               if (cnt_q == '0) state_d = StFetch;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= StFetch;
         cnt_q   <= '0;
`ifdef DECODE_SEQ_STEP_EN
         step_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef DECODE_SEQ_STEP_EN
         step_q  <= step_i;
`endif
      end
   end

   // Strobes are held back until the last cycle of a RAM access so each
   // instruction issues exactly one load/write pulse.
   always_comb begin
      word = '0;
      case (state_q)
         StFetch: begin
            word = FetchWord;
            if (!step_ok) word[12] = 1'b0;
         end
         StExec: begin
            word = exec_word;
            if (has_wait) word = word & ~StrobeMask;
         end
         StWait: begin
            word = exec_word;
            if (cnt_q != '0) word = word & ~StrobeMask;
         end
         default: word = '0;
      endcase
      if (!enable_i) word = word & ~StrobeMask;
      // Reset gates outputs combinationally, so they drop without waiting for a clock.
      if (!reset_ni) word = '0;
   end

   assign phase_o      = reset_ni && (state_q != StFetch);
   assign busy_o       = reset_ni && (state_q == StWait);
   assign inc_pc_o     = word[12];
   assign load_pc_o    = word[11];
   assign load_a_o     = word[10];
   assign load_flags_o = word[9];
   assign fun_o        = word[8:6];
   assign cs_ram_o     = word[5];
   assign we_ram_o     = word[4];
   assign oe_alu_o     = word[3];
   assign oe_in_o      = word[2];
   assign oe_oprnd_o   = word[1];
   assign load_out_o   = word[0];

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq: one instance with no wait states, one with three.
module tb_decode_seq;

   localparam logic [12:0] FETCH_W  = 13'b1000_000_001000;
   localparam logic [12:0] STROBE_M = 13'b1111_000_010001;
   localparam logic [12:0] TAKEN_W  = 13'b0100_000_001000;
   localparam logic [12:0] SKIP_W   = 13'b1000_000_001000;

   localparam logic [3:0] OP_JC = 4'b0000, OP_JNC = 4'b0001, OP_LIT = 4'b0100;
   localparam logic [3:0] OP_LD = 4'b0110, OP_JZ = 4'b1000, OP_JNZ = 4'b1001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en [2];
   logic       zf [2];
   logic       cf [2];
   logic       stp [2];
   logic [3:0] ins [2];
   wire [14:0] obs0;
   wire [14:0] obs1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_seq #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
      .clock_i(clk), .reset_ni(rst_n), .enable_i(en[0]), .z_flag_i(zf[0]), .c_flag_i(cf[0]),
`ifdef DECODE_SEQ_STEP_EN
      .step_i(stp[0]),
`endif
      .instr_i(ins[0]), .phase_o(obs0[14]), .busy_o(obs0[13]), .inc_pc_o(obs0[12]),
      .load_pc_o(obs0[11]), .load_a_o(obs0[10]), .load_flags_o(obs0[9]), .fun_o(obs0[8:6]),
      .cs_ram_o(obs0[5]), .we_ram_o(obs0[4]), .oe_alu_o(obs0[3]), .oe_in_o(obs0[2]),
      .oe_oprnd_o(obs0[1]), .load_out_o(obs0[0])
   );

   decode_seq #(.WAIT_CYCLES(3), .CNT_W(4)) u_dut1 (
      .clock_i(clk), .reset_ni(rst_n), .enable_i(en[1]), .z_flag_i(zf[1]), .c_flag_i(cf[1]),
`ifdef DECODE_SEQ_STEP_EN
      .step_i(stp[1]),
`endif
      .instr_i(ins[1]), .phase_o(obs1[14]), .busy_o(obs1[13]), .inc_pc_o(obs1[12]),
      .load_pc_o(obs1[11]), .load_a_o(obs1[10]), .load_flags_o(obs1[9]), .fun_o(obs1[8:6]),
      .cs_ram_o(obs1[5]), .we_ram_o(obs1[4]), .oe_alu_o(obs1[3]), .oe_in_o(obs1[2]),
      .oe_oprnd_o(obs1[1]), .load_out_o(obs1[0])
   );

   // Reference instruction table: execute word with the jump outcome resolved.
   function automatic logic [12:0] ref_exec(input logic [3:0] op, input logic z, input logic c);
      case (op)
         4'b0000: return c ? TAKEN_W : SKIP_W;
         4'b0001: return c ? SKIP_W : TAKEN_W;
         4'b0010: return 13'b0001_001_000010;
         4'b0011: return 13'b1001_001_100000;
         4'b0100: return 13'b0011_010_000010;
         4'b0101: return 13'b0011_010_000100;
         4'b0110: return 13'b1011_010_100000;
         4'b0111: return 13'b1000_000_111000;
         4'b1000: return z ? TAKEN_W : SKIP_W;
         4'b1001: return z ? SKIP_W : TAKEN_W;
         4'b1010: return 13'b0011_011_000010;
         4'b1011: return 13'b1011_011_100000;
         4'b1100: return 13'b0100_000_001000;
         4'b1101: return 13'b0000_000_001001;
         4'b1110: return 13'b0011_100_000010;
         default: return 13'b1011_100_100000;
      endcase
   endfunction

   // Runs one instruction through DUT idx. The expected cycle list is
   // {phase, busy, word}. A disabled cycle repeats the current entry with strobes
   // cleared and does not consume it.
   task automatic run_instr(input string name, input int idx, input logic [3:0] op,
                            input logic z, input logic c, input int frz_at, input int frz_len,
                            input bit rnd_en, output int pulses);
      logic [14:0] exp_q[$];
      logic [12:0] w;
      logic [14:0] expv;
      logic [14:0] got;
      int          nw;
      int          k;
      int          frozen;
      bit          e;
      w  = ref_exec(op, z, c);
      nw = (idx == 0) ? 0 : 3;
      exp_q.push_back({2'b00, FETCH_W});
      if (w[5] && nw > 0) begin
         exp_q.push_back({2'b10, w & ~STROBE_M});
         for (int i = 1; i < nw; i++) exp_q.push_back({2'b11, w & ~STROBE_M});
         exp_q.push_back({2'b11, w});
      end else begin
         exp_q.push_back({2'b10, w});
      end
      k = 0;
      frozen = 0;
      pulses = 0;
      while (k < exp_q.size()) begin
         @(negedge clk);
         if (k == frz_at && frozen < frz_len) begin
            e = 1'b0;
            frozen++;
         end else if (rnd_en) begin
            e = ($urandom_range(0, 3) != 0);
         end else begin
            e = 1'b1;
         end
         en[idx] = e;
         if (k == 0) begin
            ins[idx] = 4'($urandom);
            zf[idx]  = 1'($urandom);
            cf[idx]  = 1'($urandom);
         end else begin
            ins[idx] = op;
            zf[idx]  = z;
            cf[idx]  = c;
         end
         stp[idx] = (k == 0) && e;
         #1;
         expv = exp_q[k];
         if (!e) expv[12:0] = expv[12:0] & ~STROBE_M;
         got = (idx == 0) ? obs0 : obs1;
         checks++;
         if (got !== expv) begin
            errors++;
            $display("FAIL %s dut%0d op=%b cycle%0d en=%0b: got %b expected %b",
                     name, idx, op, k, e, got, expv);
         end
         if (got[10]) pulses++;
         if (e) k++;
      end
      @(posedge clk);
      #1;
      en[idx]  = 1'b0;
      stp[idx] = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            en[d]  = 1'b1;
            ins[d] = 4'($urandom);
            zf[d]  = 1'($urandom);
            cf[d]  = 1'($urandom);
            stp[d] = 1'b0;
         end
         #1;
         checks++;
         if (obs0 !== 15'd0 || obs1 !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b / %b expected all zero", obs0, obs1);
         end
      end
      @(negedge clk);
      en[0] = 1'b0;
      en[1] = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs0 !== {2'b00, FETCH_W & ~STROBE_M} || obs1 !== {2'b00, FETCH_W & ~STROBE_M}) begin
         errors++;
         $display("FAIL reset_release: got %b / %b expected %b", obs0, obs1,
                  {2'b00, FETCH_W & ~STROBE_M});
      end
   endtask

   task automatic test_basic_cycle();
      int p;
      run_instr("basic_lit", 0, OP_LIT, 1'b0, 1'b0, -1, 0, 1'b0, p);
      run_instr("basic_lit_w", 1, OP_LIT, 1'b1, 1'b1, -1, 0, 1'b0, p);
   endtask

   task automatic test_jumps();
      int p;
      run_instr("jc_taken", 0, OP_JC, 1'b0, 1'b1, -1, 0, 1'b0, p);
      run_instr("jc_skip", 0, OP_JC, 1'b1, 1'b0, -1, 0, 1'b0, p);
      run_instr("jnz_taken", 0, OP_JNZ, 1'b0, 1'b1, -1, 0, 1'b0, p);
      run_instr("jnc_taken", 1, OP_JNC, 1'b1, 1'b0, -1, 0, 1'b0, p);
      run_instr("jz_taken", 1, OP_JZ, 1'b1, 1'b0, -1, 0, 1'b0, p);
   endtask

   task automatic test_wait_states();
      int p;
      run_instr("wait_ld", 1, OP_LD, 1'b0, 1'b0, -1, 0, 1'b0, p);
      checks++;
      if (p !== 1) begin
         errors++;
         $display("FAIL wait_ld_pulses: got %0d loadA pulses expected 1", p);
      end
      run_instr("nowait_ld", 0, OP_LD, 1'b1, 1'b0, -1, 0, 1'b0, p);
   endtask

   task automatic test_enable_freeze();
      int p;
      // Cycle index 3 is the middle WAIT cycle of a three-wait-state LD.
      run_instr("freeze_ld", 1, OP_LD, 1'b0, 1'b1, 3, 5, 1'b0, p);
      checks++;
      if (p !== 1) begin
         errors++;
         $display("FAIL freeze_pulses: got %0d loadA pulses expected 1", p);
      end
   endtask

   task automatic test_async_reset_mid_wait();
      int p;
      @(negedge clk);
      en[1]  = 1'b1;
      ins[1] = OP_LD;
      zf[1]  = 1'b0;
      cf[1]  = 1'b0;
      stp[1] = 1'b1;
      @(posedge clk);
      #1 stp[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (obs1[14:13] !== 2'b11) begin
         errors++;
         $display("FAIL mid_wait_entry: got phase/busy %b expected 11", obs1[14:13]);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs1 !== 15'd0 || obs0 !== 15'd0) begin
         errors++;
         $display("FAIL async_reset_now: got %b / %b expected all zero", obs1, obs0);
      end
      en[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs1 !== {2'b00, FETCH_W & ~STROBE_M}) begin
         errors++;
         $display("FAIL async_reset_restart: got %b expected %b", obs1,
                  {2'b00, FETCH_W & ~STROBE_M});
      end
      run_instr("after_reset_ld", 1, OP_LD, 1'b1, 1'b1, -1, 0, 1'b0, p);
   endtask

   task automatic test_random();
      int p;
      int idx;
      for (int n = 0; n < 40; n++) begin
         idx = n % 2;
         run_instr("random", idx, 4'($urandom), 1'($urandom), 1'($urandom), -1, 0, 1'b1, p);
      end
   endtask

`ifdef DECODE_SEQ_STEP_EN
   task automatic test_step();
      int p;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         en[0]  = 1'b1;
         stp[0] = 1'b0;
         ins[0] = 4'($urandom);
         #1;
         checks++;
         if (obs0 !== {2'b00, FETCH_W & ~13'h1000}) begin
            errors++;
            $display("FAIL step_hold: got %b expected %b", obs0, {2'b00, FETCH_W & ~13'h1000});
         end
      end
      run_instr("step_pulse", 0, OP_LIT, 1'b0, 1'b0, -1, 0, 1'b0, p);
   endtask
`endif

   initial begin
      for (int d = 0; d < 2; d++) begin
         en[d]  = 1'b0;
         zf[d]  = 1'b0;
         cf[d]  = 1'b0;
         stp[d] = 1'b0;
         ins[d] = 4'd0;
      end
      test_reset();
      test_basic_cycle();
      test_jumps();
      test_wait_states();
      test_enable_freeze();
      test_async_reset_mid_wait();
`ifdef DECODE_SEQ_STEP_EN
      test_step();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
